// File: rtl/descr_pkg.sv
// Shared definitions for the multi-lane 64b/66b receive descrambler:
// sync-header codes, lock FSM states and the x^58 + x^39 + 1 tap positions.
package descr_pkg;

   // Valid sync headers; 2'b00 and 2'b11 are illegal on the line.
   localparam logic [1:0] SH_DATA = 2'b01;
   localparam logic [1:0] SH_CTRL = 2'b10;

   // Zero-based taps into the descrambler history (s[0] = newest bit).
   localparam int TAP0    = 38;
   localparam int TAP1    = 57;
   localparam int STATE_W = TAP1 + 1;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      LOCKED = 2'd1,
      SLIP   = 2'd2
   } lock_state_t;

   // A header is good when exactly one of its two bits is set.
   function automatic logic sh_good(input logic [1:0] sh);
      return (sh == SH_DATA) || (sh == SH_CTRL);
   endfunction

endpackage

// File: rtl/block_lock_fsm.sv
// Per-lane 64b/66b block-lock state machine. Hunts for LOCK_CNT consecutive
// good sync headers, then monitors WIN-header windows and drops lock when
// BAD_MAX bad headers land inside one window. Every loss of lock passes
// through a single-cycle SLIP state that asks the gearbox to shift by one bit.
module block_lock_fsm
   import descr_pkg::*;
#(
   parameter int LOCK_CNT = 64,
   parameter int WIN      = 64,
   parameter int BAD_MAX  = 16
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       valid_i,
   input  logic [1:0] head_i,
   output logic       lock_o,
   output logic       slip_o,
   output logic       locked_q
);

   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int WIN_W  = $clog2(WIN + 1);
   localparam int BAD_W  = $clog2(BAD_MAX + 1);

   lock_state_t       state_q;
   logic [GOOD_W-1:0] good_cnt_q;
   logic [WIN_W-1:0]  win_cnt_q;
   logic [WIN_W-1:0]  win_cnt_d;
   logic [BAD_W-1:0]  bad_cnt_q;
   logic [BAD_W-1:0]  bad_cnt_d;
   logic              lock_q;
   logic              slip_q;
   logic              head_bad;
   logic              last_good;
   logic              bad_limit;
   logic              win_end;

   // Candidate counter values for the header currently presented while locked.
   assign head_bad  = !sh_good(head_i);
   assign win_cnt_d = win_cnt_q + WIN_W'(1);
   assign bad_cnt_d = bad_cnt_q + BAD_W'(head_bad);
   assign last_good = (good_cnt_q == GOOD_W'(LOCK_CNT - 1));
   assign bad_limit = (bad_cnt_d == BAD_W'(BAD_MAX));
   assign win_end   = (win_cnt_d == WIN_W'(WIN));

   // Lock state, counters and registered status outputs in one sequential block.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q    <= HUNT;
         good_cnt_q <= '0;
         win_cnt_q  <= '0;
         bad_cnt_q  <= '0;
         lock_q     <= 1'b0;
         slip_q     <= 1'b0;
      end else begin
         case (state_q)
            HUNT: begin
               if (valid_i) begin
                  if (head_bad) begin
                     state_q    <= SLIP;
                     slip_q     <= 1'b1;
                     good_cnt_q <= '0;
                  end else if (last_good) begin
                     state_q    <= LOCKED;
                     lock_q     <= 1'b1;
                     good_cnt_q <= '0;
                     win_cnt_q  <= '0;
                     bad_cnt_q  <= '0;
                  end else begin
                     good_cnt_q <= good_cnt_q + GOOD_W'(1);
                  end
               end
            end
            LOCKED: begin
               if (valid_i) begin
                  // Too many bad headers wins over a coincident window end.
                  if (bad_limit) begin
                     state_q   <= SLIP;
                     lock_q    <= 1'b0;
                     slip_q    <= 1'b1;
                     win_cnt_q <= '0;
                     bad_cnt_q <= '0;
                  end else if (win_end) begin
                     win_cnt_q <= '0;
                     bad_cnt_q <= '0;
                  end else begin
                     win_cnt_q <= win_cnt_d;
                     bad_cnt_q <= bad_cnt_d;
                  end
               end
            end
            SLIP: begin
               // One cycle only; any header seen here is deliberately ignored.
               state_q    <= HUNT;
               slip_q     <= 1'b0;
               lock_q     <= 1'b0;
               good_cnt_q <= '0;
               win_cnt_q  <= '0;
               bad_cnt_q  <= '0;
            end
            default: begin
               state_q    <= HUNT;
               slip_q     <= 1'b0;
               lock_q     <= 1'b0;
               good_cnt_q <= '0;
               win_cnt_q  <= '0;
               bad_cnt_q  <= '0;
            end
         endcase
      end
   end

   assign lock_o   = lock_q;
   assign slip_o   = slip_q;
   assign locked_q = lock_q;

endmodule

// File: rtl/descrambler_mlane.sv
// LANE_N independent 64b/66b receive lanes. Each lane runs a self-synchronising
// x^58 + x^39 + 1 descrambler over its payload, passes the sync header through,
// registers the results and tracks block lock with its own block_lock_fsm.
module descrambler_mlane
   import descr_pkg::*;
#(
   parameter int LANE_N   = 4,
   parameter int DATA_W   = 64,
   parameter int LOCK_CNT = 64,
   parameter int WIN      = 64,
   parameter int BAD_MAX  = 16
) (
   input  logic                     clk,
   input  logic                     nreset,
   input  logic [LANE_N-1:0]        valid_i,
   input  logic [2*LANE_N-1:0]      head_i,
   input  logic [DATA_W*LANE_N-1:0] data_i,
   input  logic                     bypass_i,
   output logic [LANE_N-1:0]        valid_o,
   output logic [2*LANE_N-1:0]      head_o,
   output logic [DATA_W*LANE_N-1:0] data_o,
   output logic [LANE_N-1:0]        lock_o,
   output logic [LANE_N-1:0]        slip_o
);

   // Offsets into the extended vector {payload, reversed history} for the taps.
   localparam int OFF0 = STATE_W - TAP0 - 1;
   localparam int OFF1 = STATE_W - TAP1 - 1;
   localparam int EXT_W = DATA_W + STATE_W;

   for (genvar l = 0; l < LANE_N; l++) begin : g_lane

      logic [DATA_W-1:0]  din;
      logic [DATA_W-1:0]  desc;
      logic [EXT_W-1:0]   ext;
      logic [STATE_W-1:0] scr_q;
      logic [STATE_W-1:0] scr_d;
      logic [DATA_W-1:0]  data_q;
      logic [1:0]         head_q;
      logic               valid_q;
      logic               locked;

      assign din = data_i[DATA_W*l +: DATA_W];

      // Parallel descramble: lay history (oldest first) under the payload so
      // bit i sees x(i-39) at ext[i+OFF0] and x(i-58) at ext[i+OFF1].
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      always_comb begin
         ext   = '0;
         desc  = '0;
         scr_d = '0;
         for (int k = 0; k < STATE_W; k++) begin
            ext[k]   = scr_q[STATE_W-1-k];
            scr_d[k] = din[DATA_W-1-k];
         end
         ext[STATE_W +: DATA_W] = din;
         for (int i = 0; i < DATA_W; i++) begin
            desc[i] = din[i] ^ ext[i+OFF0] ^ ext[i+OFF1];
         end
      end

      // Scrambler history and output registers; history tracks every valid
      // block even while unlocked or bypassed so it is ready when needed.
      // NOTE: the history is reset to all ones because that seed defines the
      // first 58 descrambled bits after reset, unlike plain data registers.
      always_ff @(posedge clk or negedge nreset) begin
         if (!nreset) begin
            scr_q   <= '1;
            data_q  <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            valid_q <= valid_i[l] && locked;
            if (valid_i[l]) begin
               scr_q  <= scr_d;
               head_q <= head_i[2*l +: 2];
               data_q <= bypass_i ? din : desc;
            end
         end
      end

      block_lock_fsm #(
         .LOCK_CNT (LOCK_CNT),
         .WIN      (WIN),
         .BAD_MAX  (BAD_MAX)
      ) u_lock (
         .clk      (clk),
         .nreset   (nreset),
         .valid_i  (valid_i[l]),
         .head_i   (head_i[2*l +: 2]),
         .lock_o   (lock_o[l]),
         .slip_o   (slip_o[l]),
         .locked_q (locked)
      );

      assign data_o[DATA_W*l +: DATA_W] = data_q;
      assign head_o[2*l +: 2]           = head_q;
      assign valid_o[l]                 = valid_q;

   end

endmodule
